reset_sequencer: RTL and testbench



---
 rtl/reset_sequencer_if.sv | 48 ++++
 rtl/reset_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_reset_sequencer.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/reset_sequencer_if.sv
// ---------------------------------------------------------------------------
// reset_sequencer_if
// Purpose : Groups the PHY-facing signals of the reset sequencer into one bundle.
// Signals :
//   pll_lock_i      - PLL lock status, synchronous to the sequencer clock
//   pll_rst_o       - PLL reset, active-high
//   pcs_rst_o       - PCS reset, active-high
//   mac_rst_o       - MAC reset, active-high
//   seq_done_o      - high while the sequencer is in RUN
//   timeout_o       - high while the sequencer is in FAULT
//   state_o         - current state encoding (debug / status)
//   lock_loss_cnt_o - saturating count of lock-loss events
// Modports:
//   master - the sequencer (drives the resets and status)
//   slave  - the PHY / bench side (drives lock, observes the rest)
// ---------------------------------------------------------------------------
interface reset_sequencer_if;
  logic       pll_lock_i;
  logic       pll_rst_o;
  logic       pcs_rst_o;
  logic       mac_rst_o;
  logic       seq_done_o;
  logic       timeout_o;
  logic [2:0] state_o;
  logic [7:0] lock_loss_cnt_o;

  modport master (
    input  pll_lock_i,
    output pll_rst_o,
    output pcs_rst_o,
    output mac_rst_o,
    output seq_done_o,
    output timeout_o,
    output state_o,
    output lock_loss_cnt_o
  );

  modport slave (
    output pll_lock_i,
    input  pll_rst_o,
    input  pcs_rst_o,
    input  mac_rst_o,
    input  seq_done_o,
    input  timeout_o,
    input  state_o,
    input  lock_loss_cnt_o
  );
endinterface

// File: rtl/reset_sequencer.sv
// ---------------------------------------------------------------------------
// reset_sequencer
// Purpose : After rst_i releases, releases the PHY resets in order PLL -> PCS
//           -> MAC. PCS release waits for a stable PLL lock; a lock that never
//           settles ends in a sticky FAULT; a lock drop after PCS release
//           restarts the sequence from PLL_HOLD and is counted.
// Ports   :
//   clk_i   - sequencer clock
//   rst_i   - synchronous, active-high reset
//   seq_if  - reset_sequencer_if.master (lock input, resets, status)
// Handshake: none; every output is a registered level. pll_lock_i is a level
//   sampled on each rising clk_i edge; no valid/ready pairs exist here.
// ---------------------------------------------------------------------------
module reset_sequencer #(
  parameter int HOLD_CYCLES  = 16,
  parameter int LOCK_STABLE  = 4,
  parameter int LOCK_TIMEOUT = 1024,
  parameter int STAGE_GAP    = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  reset_sequencer_if.master  seq_if
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES) + 1;
  localparam int STAB_W = $clog2(LOCK_STABLE) + 1;
  localparam int TMO_W  = $clog2(LOCK_TIMEOUT) + 1;
  localparam int GAP_W  = $clog2(STAGE_GAP) + 1;

  // Terminal values: the transition fires on the edge where the counter
  // would reach its parameter, i.e. when the current value is parameter-1.
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(LOCK_TIMEOUT - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(STAGE_GAP - 1);

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_PLL_HOLD  = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_PCS_REL   = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAULT     = 3'd5
  } state_e;

  state_e              state_q,    state_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [STAB_W-1:0]   stab_cnt_q, stab_cnt_d;
  logic [TMO_W-1:0]    tmo_cnt_q,  tmo_cnt_d;
  logic [GAP_W-1:0]    gap_cnt_q,  gap_cnt_d;
  logic                pll_rst_q,  pll_rst_d;
  logic                pcs_rst_q,  pcs_rst_d;
  logic                mac_rst_q,  mac_rst_d;
  logic                seq_done_q, seq_done_d;
  logic                timeout_q,  timeout_d;
  logic [7:0]          loss_cnt_q, loss_cnt_d;

  logic                lock;

  assign lock = seq_if.pll_lock_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_RESET;
      hold_cnt_q <= '0;
      stab_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      pll_rst_q  <= 1'b1;
      pcs_rst_q  <= 1'b1;
      mac_rst_q  <= 1'b1;
      seq_done_q <= 1'b0;
      timeout_q  <= 1'b0;
      loss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      stab_cnt_q <= stab_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      pll_rst_q  <= pll_rst_d;
      pcs_rst_q  <= pcs_rst_d;
      mac_rst_q  <= mac_rst_d;
      seq_done_q <= seq_done_d;
      timeout_q  <= timeout_d;
      loss_cnt_q <= loss_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    stab_cnt_d = stab_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    pll_rst_d  = pll_rst_q;
    pcs_rst_d  = pcs_rst_q;
    mac_rst_d  = mac_rst_q;
    seq_done_d = seq_done_q;
    timeout_d  = timeout_q;
    loss_cnt_d = loss_cnt_q;

    case (state_q)
      ST_RESET: begin
        state_d    = ST_PLL_HOLD;
        hold_cnt_d = '0;
        pll_rst_d  = 1'b1;
        pcs_rst_d  = 1'b1;
        mac_rst_d  = 1'b1;
        seq_done_d = 1'b0;
        timeout_d  = 1'b0;
      end

      // Lock is deliberately not examined while the PLL is held in reset.
      ST_PLL_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          pll_rst_d  = 1'b0;
          state_d    = ST_WAIT_LOCK;
          stab_cnt_d = '0;
          tmo_cnt_d  = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end

      // Stability is tested before timeout so a lock that settles on the
      // very last allowed edge still releases PCS.
      ST_WAIT_LOCK: begin
        stab_cnt_d = lock ? stab_cnt_q + 1'b1 : '0;
        tmo_cnt_d  = tmo_cnt_q + 1'b1;
        if (lock && (stab_cnt_q == STAB_LAST)) begin
          pcs_rst_d = 1'b0;
          state_d   = ST_PCS_REL;
          gap_cnt_d = '0;
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d   = ST_FAULT;
          timeout_d = 1'b1;
          pll_rst_d = 1'b1;
        end
      end

      ST_PCS_REL: begin
        if (!lock) begin
          state_d    = ST_PLL_HOLD;
          hold_cnt_d = '0;
          pll_rst_d  = 1'b1;
          pcs_rst_d  = 1'b1;
          mac_rst_d  = 1'b1;
          seq_done_d = 1'b0;
          loss_cnt_d = (loss_cnt_q == 8'hff) ? loss_cnt_q : loss_cnt_q + 8'd1;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
          if (gap_cnt_q == GAP_LAST) begin
            mac_rst_d  = 1'b0;
            seq_done_d = 1'b1;
            state_d    = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        if (!lock) begin
          state_d    = ST_PLL_HOLD;
          hold_cnt_d = '0;
          pll_rst_d  = 1'b1;
          pcs_rst_d  = 1'b1;
          mac_rst_d  = 1'b1;
          seq_done_d = 1'b0;
          loss_cnt_d = (loss_cnt_q == 8'hff) ? loss_cnt_q : loss_cnt_q + 8'd1;
        end else begin
          pll_rst_d = 1'b0;
          pcs_rst_d = 1'b0;
          mac_rst_d = 1'b0;
        end
      end

      // Sticky until rst_i; only the reset branch of the register leaves here.
      ST_FAULT: begin
        pll_rst_d  = 1'b1;
        pcs_rst_d  = 1'b1;
        mac_rst_d  = 1'b1;
        seq_done_d = 1'b0;
        timeout_d  = 1'b1;
      end

      // Unused encodings 6 and 7 fall back to RESET.
      default: begin
        state_d    = ST_RESET;
        pll_rst_d  = 1'b1;
        pcs_rst_d  = 1'b1;
        mac_rst_d  = 1'b1;
        seq_done_d = 1'b0;
        timeout_d  = 1'b0;
      end
    endcase
  end

  assign seq_if.pll_rst_o       = pll_rst_q;
  assign seq_if.pcs_rst_o       = pcs_rst_q;
  assign seq_if.mac_rst_o       = mac_rst_q;
  assign seq_if.seq_done_o      = seq_done_q;
  assign seq_if.timeout_o       = timeout_q;
  assign seq_if.state_o         = state_q;
  assign seq_if.lock_loss_cnt_o = loss_cnt_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// ---------------------------------------------------------------------------
// tb_reset_sequencer
// Directed bench for reset_sequencer with default parameters. Inputs change
// 1 ns after a rising edge; outputs are read at that same point, so after
// tick() the values shown are those registered at the edge just taken.
// ---------------------------------------------------------------------------
module tb_reset_sequencer;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  reset_sequencer_if seq_if ();

  reset_sequencer #(
    .HOLD_CYCLES  (16),
    .LOCK_STABLE  (4),
    .LOCK_TIMEOUT (1024),
    .STAGE_GAP    (8)
  ) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .seq_if (seq_if.master)
  );

  // Clock / reset block
  always #5 clk_i = ~clk_i;

  // Driver tasks
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic pll, input logic pcs, input logic mac,
                            input logic done, input logic tmo, input logic [2:0] st,
                            input logic [7:0] cnt);
    check({tag, ".pll_rst"},  32'(seq_if.pll_rst_o),       32'(pll));
    check({tag, ".pcs_rst"},  32'(seq_if.pcs_rst_o),       32'(pcs));
    check({tag, ".mac_rst"},  32'(seq_if.mac_rst_o),       32'(mac));
    check({tag, ".seq_done"}, 32'(seq_if.seq_done_o),      32'(done));
    check({tag, ".timeout"},  32'(seq_if.timeout_o),       32'(tmo));
    check({tag, ".state"},    32'(seq_if.state_o),         32'(st));
    check({tag, ".loss_cnt"}, 32'(seq_if.lock_loss_cnt_o), 32'(cnt));
  endtask

  logic [7:0] pat;
  int         exp_cnt;

  initial begin
    seq_if.pll_lock_i = 1'b1;
    rst_i = 1'b1;
    tick_n(3);
    check_outs("reset", 1, 1, 1, 0, 0, 3'd0, 8'd0);

    // 1: lock high throughout
    rst_i = 1'b0;
    tick();                                   // E0
    check_outs("t1_e0", 1, 1, 1, 0, 0, 3'd1, 8'd0);
    tick_n(15);                               // E15
    check_outs("t1_e15", 1, 1, 1, 0, 0, 3'd1, 8'd0);
    tick();                                   // E16
    check_outs("t1_e16", 0, 1, 1, 0, 0, 3'd2, 8'd0);
    tick_n(3);                                // E19
    check_outs("t1_e19", 0, 1, 1, 0, 0, 3'd2, 8'd0);
    tick();                                   // E20
    check_outs("t1_e20", 0, 0, 1, 0, 0, 3'd3, 8'd0);
    tick_n(7);                                // E27
    check_outs("t1_e27", 0, 0, 1, 0, 0, 3'd3, 8'd0);
    tick();                                   // E28
    check_outs("t1_e28", 0, 0, 0, 1, 0, 3'd4, 8'd0);

    // 2: lock glitch during WAIT_LOCK restarts stability count
    rst_i = 1'b1;
    tick_n(2);
    check_outs("t2_rst", 1, 1, 1, 0, 0, 3'd0, 8'd0);
    rst_i = 1'b0;
    tick();                                   // E0
    tick_n(16);                               // E16
    check_outs("t2_e16", 0, 1, 1, 0, 0, 3'd2, 8'd0);
    pat = 8'b1111_0111;                       // bit i -> edge E(17+i)
    for (int i = 0; i < 8; i++) begin
      seq_if.pll_lock_i = pat[i];
      tick();
      if (i == 3) check_outs("t2_e20", 0, 1, 1, 0, 0, 3'd2, 8'd0);
      if (i == 6) check_outs("t2_e23", 0, 1, 1, 0, 0, 3'd2, 8'd0);
    end
    check_outs("t2_e24", 0, 0, 1, 0, 0, 3'd3, 8'd0);
    seq_if.pll_lock_i = 1'b1;
    tick_n(7);                                // E31
    check_outs("t2_e31", 0, 0, 1, 0, 0, 3'd3, 8'd0);
    tick();                                   // E32
    check_outs("t2_e32", 0, 0, 0, 1, 0, 3'd4, 8'd0);

    // 3: lock never arrives -> sticky FAULT
    rst_i = 1'b1;
    seq_if.pll_lock_i = 1'b0;
    tick();
    rst_i = 1'b0;
    tick();                                   // E0
    tick_n(1039);                             // E1039
    check_outs("t3_e1039", 0, 1, 1, 0, 0, 3'd2, 8'd0);
    tick();                                   // E1040
    check_outs("t3_e1040", 1, 1, 1, 0, 1, 3'd5, 8'd0);
    seq_if.pll_lock_i = 1'b1;                 // late lock must not rescue FAULT
    tick_n(3960);                             // E5000
    check_outs("t3_e5000", 1, 1, 1, 0, 1, 3'd5, 8'd0);
    rst_i = 1'b1;
    tick();
    check_outs("t3_clear", 1, 1, 1, 0, 0, 3'd0, 8'd0);

    // 4: single-cycle lock loss in RUN
    rst_i = 1'b0;
    tick();                                   // E0
    tick_n(28);                               // E28
    check_outs("t4_run", 0, 0, 0, 1, 0, 3'd4, 8'd0);
    tick_n(5);
    seq_if.pll_lock_i = 1'b0;
    tick();                                   // Ek
    check_outs("t4_ek", 1, 1, 1, 0, 0, 3'd1, 8'd1);
    seq_if.pll_lock_i = 1'b1;
    tick_n(15);                               // E(k+15)
    check_outs("t4_k15", 1, 1, 1, 0, 0, 3'd1, 8'd1);
    tick();                                   // E(k+16)
    check_outs("t4_k16", 0, 1, 1, 0, 0, 3'd2, 8'd1);

    // 5: bring loss count to 3, then reset pulse in WAIT_LOCK
    tick_n(4);
    check_outs("t5_pcs1", 0, 0, 1, 0, 0, 3'd3, 8'd1);
    seq_if.pll_lock_i = 1'b0;                 // loss in PCS_REL
    tick();
    check_outs("t5_loss2", 1, 1, 1, 0, 0, 3'd1, 8'd2);
    seq_if.pll_lock_i = 1'b1;
    tick_n(20);
    check_outs("t5_pcs2", 0, 0, 1, 0, 0, 3'd3, 8'd2);
    seq_if.pll_lock_i = 1'b0;
    tick();
    check_outs("t5_loss3", 1, 1, 1, 0, 0, 3'd1, 8'd3);
    tick_n(16);                               // lock low ignored in PLL_HOLD
    check_outs("t5_wait", 0, 1, 1, 0, 0, 3'd2, 8'd3);
    tick_n(2);
    rst_i = 1'b1;
    tick();
    check_outs("t5_rst", 1, 1, 1, 0, 0, 3'd0, 8'd0);
    rst_i = 1'b0;
    seq_if.pll_lock_i = 1'b1;
    tick();
    check_outs("t5_e0", 1, 1, 1, 0, 0, 3'd1, 8'd0);
    tick_n(16);
    check_outs("t5_e16", 0, 1, 1, 0, 0, 3'd2, 8'd0);
    tick_n(4);
    check_outs("t5_e20", 0, 0, 1, 0, 0, 3'd3, 8'd0);
    tick_n(8);
    check_outs("t5_e28", 0, 0, 0, 1, 0, 3'd4, 8'd0);

    // 6: 300 lock-loss events, count saturates at 255
    exp_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      seq_if.pll_lock_i = 1'b0;
      tick();
      exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
      check("t6_cnt", 32'(seq_if.lock_loss_cnt_o), 32'(exp_cnt));
      seq_if.pll_lock_i = 1'b1;
      tick_n(20);
      check("t6_relock", 32'(seq_if.state_o), 32'd3);
    end
    check_outs("t6_final", 0, 0, 1, 0, 0, 3'd3, 8'd255);
    tick_n(8);
    check_outs("t6_run", 0, 0, 0, 1, 0, 3'd4, 8'd255);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
